// File: rtl/mac_pkg.sv
// Shared constants and state types for the MAC array frame feeder.
// Frame geometry is fixed here; the top only adds the multiplier latency.
package mac_pkg;

  localparam int N          = 576;
  localparam int BEAT_BYTES = 8;
  localparam int NUM_ACC    = 8;
  localparam int BEATS      = N / BEAT_BYTES;
  localparam int BEAT_W     = 8 * BEAT_BYTES;
  localparam int FRAME_W    = 8 * N;
  localparam int CNT_W      = $clog2(BEATS);

  typedef enum logic [1:0] {
    LD_LOAD,
    LD_FULL,
    LD_DRAIN
  } ld_state_e;

  typedef enum logic [1:0] {
    IS_IDLE,
    IS_SETTLE,
    IS_FIRE,
    IS_WAIT
  } is_state_e;

endpackage

// File: rtl/mac_frame_loader.sv
// Beat assembler: packs streaming beats into the frame load buffer
// and hands a full buffer to the issue logic via full/ack.
module mac_frame_loader
  import mac_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [BEAT_W-1:0]  data_i,
  input  logic               valid_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic               full_o,
  input  logic               ack_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               err_o
);

  ld_state_e                    state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BEATS-1:0][BEAT_W-1:0] buf_q;
  logic                         drain_q, drain_d;
  logic                         err_q, err_d;
  logic                         live_q;
  logic                         acc;
  logic                         at_end;

  // live_q keeps ready low while reset is held
  assign ready_o = live_q & (state_q != LD_FULL);
  assign acc     = valid_i & ready_o;
  assign at_end  = cnt_q == CNT_W'(BEATS - 1);
  assign full_o  = state_q == LD_FULL;
  assign frame_o = buf_q;
  assign err_o   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    err_d   = 1'b0;
    unique case (state_q)
      LD_LOAD: begin
        if (acc) begin
          if (at_end) begin
            state_d = LD_FULL;
            drain_d = ~last_i;
            err_d   = ~last_i;
          end else if (last_i) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LD_FULL: begin
        if (ack_i) begin
          state_d = drain_q ? LD_DRAIN : LD_LOAD;
          cnt_d   = '0;
          drain_d = 1'b0;
        end
      end
      LD_DRAIN: begin
        if (acc && last_i) state_d = LD_LOAD;
      end
      default: state_d = LD_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LD_LOAD;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
      if (acc && state_q == LD_LOAD) buf_q[cnt_q] <= data_i;
    end
  end

endmodule

// File: rtl/mac_frame_feeder.sv
// MAC array initiator: holds a frame on din_o, strobes the adder
// lanes after the multiplier latency and waits for every lane.
module mac_frame_feeder
  import mac_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BEAT_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  output logic [FRAME_W-1:0] din_o,
  output logic [NUM_ACC-1:0] vld_o,
  input  logic [NUM_ACC-1:0] sum_vld_i,
  output logic               busy,
  output logic               frame_err,
  output logic [15:0]        frame_cnt
);

  is_state_e          st_q, st_d;
  logic [3:0]         lat_q, lat_d;
  logic [NUM_ACC-1:0] done_q, done_d;
  logic [NUM_ACC-1:0] seen;
  logic [15:0]        cnt_q, cnt_d;
  logic [FRAME_W-1:0] din_q;
  logic [FRAME_W-1:0] frame;
  logic               full;
  logic               xfer;

  mac_frame_loader u_loader (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (s_data),
    .valid_i (s_valid),
    .last_i  (s_last),
    .ready_o (s_ready),
    .full_o  (full),
    .ack_i   (xfer),
    .frame_o (frame),
    .err_o   (frame_err)
  );

  assign xfer      = full & (st_q == IS_IDLE);
  assign seen      = done_q | sum_vld_i;
  assign din_o     = din_q;
  assign busy      = st_q != IS_IDLE;
  assign frame_cnt = cnt_q;

  always_comb begin
    st_d   = st_q;
    lat_d  = lat_q;
    done_d = done_q;
    cnt_d  = cnt_q;
    vld_o  = '0;
    unique case (st_q)
      IS_IDLE: begin
        if (xfer) begin
          st_d  = IS_SETTLE;
          lat_d = '0;
        end
      end
      IS_SETTLE: begin
        if (lat_q == 4'(MUL_LAT)) st_d = IS_FIRE;
        else lat_d = lat_q + 4'd1;
      end
      IS_FIRE: begin
        vld_o  = '1;
        done_d = '0;
        st_d   = IS_WAIT;
      end
      IS_WAIT: begin
        // lanes finishing in this very cycle count toward completion
        done_d = seen;
        if (&seen) begin
          st_d  = IS_IDLE;
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: st_d = IS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IS_IDLE;
      lat_q  <= '0;
      done_q <= '0;
      cnt_q  <= '0;
      din_q  <= '0;
    end else begin
      st_q   <= st_d;
      lat_q  <= lat_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      if (xfer) din_q <= frame;
    end
  end

endmodule

// File: tb/tb_mac_frame_feeder.sv
// Directed and randomised checks of mac_frame_feeder against a
// frame-level model of the beat stream and adder handshake.
module tb_mac_frame_feeder;
  import mac_pkg::*;

  localparam int MUL_LAT = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [BEAT_W-1:0]  s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic               s_ready;
  logic [FRAME_W-1:0] din_o;
  logic [NUM_ACC-1:0] vld_o;
  logic [NUM_ACC-1:0] sum_vld_i = '0;
  logic               busy;
  logic               frame_err;
  logic [15:0]        frame_cnt;

  mac_frame_feeder #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .din_o     (din_o),
    .vld_o     (vld_o),
    .sum_vld_i (sum_vld_i),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [FRAME_W-1:0] exp_q[$];
  logic [FRAME_W-1:0] cur_f = '0;
  logic [FRAME_W-1:0] ef;
  int  nb = 0;
  bit  drain = 1'b0;
  int  exp_err = 0;
  int  err_seen = 0;
  int  rd_idx = 0;
  int  exp_cnt = 0;
  int  cyc = 0;
  int  since = 0;
  int  done_cyc = 0;
  int  last_gap = 0;
  int  dly = 0;
  int  sidx = 0;
  int  fb = 0;
  bit  in_wait = 1'b0;
  bit  just_done = 1'b0;
  bit  busy_q = 1'b0;
  bit  vld_q = 1'b0;
  bit  gap_en = 1'b0;
  logic [7:0] mask = '0;
  logic [7:0] lanes = '0;
  int  rsp_mode = 2;
  int  rsp_delay = 0;
  int  seq [9] = '{0, 1, 2, 3, 3, 4, 5, 6, 7};
  int  t;
  int  kind;
  int  nbr;
  int  e0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level view of the accepted beat stream.
  task automatic model_beat(input logic [63:0] d, input logic l);
    if (drain) begin
      if (l) drain = 1'b0;
    end else begin
      cur_f[64*nb +: 64] = d;
      nb++;
      if (nb == BEATS) begin
        exp_q.push_back(cur_f);
        nb = 0;
        if (!l) begin
          exp_err++;
          drain = 1'b1;
        end
      end else if (l) begin
        exp_err++;
        nb = 0;
      end
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int   tt = 0;
    logic acc = 1'b0;
    if (gap_en)
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      #1 acc = s_ready;
      @(negedge clk);
      tt++;
    end while (!acc && tt < 600);
    if (acc) model_beat(d, l);
    else chk("beat_timeout", 64'(s_ready), 64'(1));
  endtask

  task automatic send_frame(input int nbeats, input int last_at,
                            input bit pat);
    logic [63:0] d;
    for (int k = 0; k < nbeats; k++) begin
      for (int j = 0; j < 8; j++)
        d[8*j +: 8] = pat ? 8'(8*k + j) : 8'($urandom);
      send_beat(d, k == last_at);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int tt = 0;
    while ((busy || in_wait || rd_idx < exp_q.size()) && tt < 3000) begin
      @(negedge clk);
      #2;
      tt++;
    end
    chk("idle_timeout", 64'(tt < 3000), 64'(1));
  endtask

  task automatic rst_zero(input string tag);
    chk({tag, "_rdy"}, 64'(s_ready), 64'(0));
    chk({tag, "_din"}, 64'(|din_o), 64'(0));
    chk({tag, "_vld"}, 64'(vld_o), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_err"}, 64'(frame_err), 64'(0));
    chk({tag, "_cnt"}, 64'(frame_cnt), 64'(0));
  endtask

  // Observes outputs every falling edge and plays the adder lanes.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_wait   = 1'b0;
        just_done = 1'b0;
        exp_cnt   = 0;
        busy_q    = 1'b0;
        vld_q     = 1'b0;
        rd_idx    = exp_q.size();
        sum_vld_i = '0;
      end else begin
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt[15:0]));
        if (frame_err) err_seen++;
        if (busy && !busy_q) begin
          since    = 0;
          last_gap = cyc - done_cyc;
        end else begin
          since++;
        end
        busy_q = busy;
        if (just_done) chk("idle_after_done", 64'(busy), 64'(0));
        just_done = 1'b0;
        if (in_wait) chk("busy_in_wait", 64'(busy), 64'(1));
        if (vld_o != '0) begin
          if (vld_q || rd_idx >= exp_q.size()) begin
            chk("spurious_vld", 64'(vld_o), 64'(0));
          end else begin
            chk("vld_all", 64'(vld_o), 64'hFF);
            chk("settle_lat", 64'(since), 64'(MUL_LAT + 1));
            ef = exp_q[rd_idx];
            rd_idx++;
            fb = 0;
            for (int b = 0; b < BEATS; b++)
              if (din_o[64*b +: 64] !== ef[64*b +: 64]) begin
                fb = b;
                break;
              end
            chk($sformatf("din_beat%0d", fb), din_o[64*fb +: 64],
                ef[64*fb +: 64]);
            in_wait   = 1'b1;
            mask      = '0;
            dly       = rsp_delay;
            sidx      = 0;
            sum_vld_i = (rsp_mode == 0) ? 8'($urandom) : 8'h00;
          end
        end else if (in_wait) begin
          if (dly > 0) begin
            dly--;
            sum_vld_i = '0;
          end else begin
            case (rsp_mode)
              1: begin
                lanes = (sidx < 9) ? 8'(1 << seq[sidx]) : 8'h00;
                sidx++;
              end
              2: lanes = 8'hFF;
              default:
                lanes = ($urandom_range(0, 3) == 0) ? 8'h00
                      : 8'(1 << $urandom_range(0, 7));
            endcase
            sum_vld_i = lanes;
            mask      = mask | lanes;
            if (mask == 8'hFF) begin
              in_wait   = 1'b0;
              exp_cnt++;
              just_done = 1'b1;
              done_cyc  = cyc;
            end
          end
        end else begin
          sum_vld_i = '0;
        end
        vld_q = vld_o != '0;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    rst = 1'b1;
    #1;
    rst_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1 chk("rdy_after_rst", 64'(s_ready), 64'(1));

    // single frame, byte = index mod 256, all lanes 3 cycles after FIRE
    rsp_mode  = 2;
    rsp_delay = 2;
    send_frame(BEATS, BEATS - 1, 1'b1);
    wait_idle();
    chk("byte575", 64'(din_o[8*575 +: 8]), 64'h3F);
    chk("cnt_single", 64'(frame_cnt), 64'd1);
    chk("busy_single", 64'(busy), 64'(0));

    // back-to-back frames with a slow first completion
    rsp_delay = 100;
    send_frame(BEATS, BEATS - 1, 1'b0);
    send_frame(BEATS, BEATS - 1, 1'b0);
    rsp_delay = 0;
    t = 0;
    while (frame_cnt == 16'd1 && t < 400) begin
      chk("rdy_held", 64'(s_ready), 64'(0));
      @(negedge clk);
      #1;
      t++;
    end
    wait_idle();
    chk("b2b_gap", 64'(last_gap), 64'd2);
    chk("cnt_b2b", 64'(frame_cnt), 64'd3);

    // staggered lanes with a repeated lane
    rsp_mode = 1;
    send_frame(BEATS, BEATS - 1, 1'b0);
    wait_idle();
    chk("cnt_stagger", 64'(frame_cnt), 64'd4);

    // early s_last on beat 10
    rsp_mode = 2;
    e0 = err_seen;
    send_frame(11, 10, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    chk("early_err", 64'(err_seen - e0), 64'd1);
    chk("early_noissue", 64'(busy), 64'(0));
    send_frame(BEATS, BEATS - 1, 1'b1);
    wait_idle();
    chk("cnt_early", 64'(frame_cnt), 64'd5);

    // missing s_last, three extra beats, then a clean frame
    e0 = err_seen;
    send_frame(BEATS, -1, 1'b0);
    send_frame(3, 2, 1'b0);
    send_frame(BEATS, BEATS - 1, 1'b1);
    wait_idle();
    chk("miss_err", 64'(err_seen - e0), 64'd1);
    chk("cnt_miss", 64'(frame_cnt), 64'd7);

    // reset while waiting on the adders
    rsp_delay = 40;
    send_frame(BEATS, BEATS - 1, 1'b0);
    t = 0;
    while (!in_wait && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("reach_wait", 64'(busy), 64'(1));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    rst_zero("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    nb        = 0;
    drain     = 1'b0;
    rsp_delay = 0;
    @(negedge clk);
    #1 chk("rdy_after_midrst", 64'(s_ready), 64'(1));
    send_frame(BEATS, BEATS - 1, 1'b1);
    wait_idle();
    chk("cnt_after_rst", 64'(frame_cnt), 64'd1);

    // random traffic with gaps, framing errors and random lanes
    gap_en = 1'b1;
    for (int f = 0; f < 14; f++) begin
      rsp_mode  = 0;
      rsp_delay = $urandom_range(0, 5);
      kind      = $urandom_range(0, 5);
      if (kind == 0) begin
        nbr = $urandom_range(1, BEATS - 1);
        send_frame(nbr, nbr - 1, 1'b0);
      end else if (kind == 1) begin
        nbr = $urandom_range(1, 3);
        send_frame(BEATS, -1, 1'b0);
        send_frame(nbr, nbr - 1, 1'b0);
      end else begin
        send_frame(BEATS, BEATS - 1, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge clk);
    #2;
    chk("err_total", 64'(err_seen), 64'(exp_err));
    chk("cnt_final", 64'(frame_cnt), 64'(exp_cnt[15:0]));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_frame_feeder.md
Name: mac_frame_feeder

Overview:
- Initiator side of the MAC array's data/valid interface.
- Assembles a 576-byte input feature frame from a 64-bit streaming bus.
- Holds the frame stable on the array's data bus, then pulses the eight per-adder valid strobes after the multiplier latency.
- Waits for all eight adder valid outputs before presenting the next frame; loading of frame k+1 overlaps processing of frame k (load buffer plus hold register).

Parameters:
- N, 576, bytes per frame (din width = 8*N).
- BEAT_BYTES, 8, bytes per input beat; N must be a multiple of BEAT_BYTES (72 beats at defaults).
- MUL_LAT, 1, cycles from din change to valid multiplier products; range 0..15.
- NUM_ACC, 8, number of adder lanes.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8*BEAT_BYTES  frame beat; byte j of beat k maps to din byte 8k+j (bits [64k+63:64k]).
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid & s_ready.
- s_last  in  1  marks the final beat of a frame.
- din_o  out  8*N  frame to the MAC array; changes only on hold transfer.
- vld_o  out  NUM_ACC  one-cycle valid strobes to adder lanes 1..8.
- sum_vld_i  in  NUM_ACC  adder lane valid outputs.
- busy  out  1  issue FSM not in IDLE.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0.

Behaviour:
- Reset: all outputs 0 (s_ready=0, din_o=0, vld_o=0, busy=0, frame_err=0, frame_cnt=0). Load buffer, beat counter and done mask are cleared; FSMs go to LOAD / IDLE. The first cycle after rst deasserts, s_ready=1.
- Loader FSM states:
  - LOAD: s_ready=1. Each accepted beat is written at beat_cnt, which then increments. When the beat at index N/BEAT_BYTES-1 is accepted, the buffer is full -> FULL.
  - FULL: s_ready=0 until the hold transfer, then -> LOAD with beat_cnt=0.
  - DRAIN: s_ready=1; beats are discarded until an accepted beat has s_last=1, then -> LOAD.
- Framing rules:
  - s_last on a beat before the final index: frame_err pulse, partial frame discarded, beat_cnt=0, stay in LOAD.
  - Final-index beat without s_last: frame_err pulse; the frame is still treated as complete (-> FULL). After the transfer the loader enters DRAIN instead of LOAD.
- Hold transfer: happens in the cycle where loader=FULL and issue=IDLE. din_o <= load buffer on that edge, and issue -> SETTLE with the latency counter at 0.
- Issue FSM states:
  - IDLE: busy=0.
  - SETTLE: count MUL_LAT cycles. With MUL_LAT=0, skip directly to FIRE on the next cycle.
  - FIRE: vld_o = all ones for exactly one cycle; clear the done mask; -> WAIT.
  - WAIT: done[i] is set sticky on sum_vld_i[i]. When the mask plus the current sum_vld_i covers all lanes -> IDLE and frame_cnt increments.
- Latency:
  - Final beat accepted with issue idle: din_o updates 1 cycle later; vld_o pulses MUL_LAT+1 cycles after din_o updates.
  - Completion to next transfer: at least 1 IDLE cycle (one-cycle bubble, intentional).
- sum_vld_i is ignored outside WAIT, including pulses arriving during FIRE. Duplicate lane pulses in WAIT are harmless.
- din_o is stable from transfer through return to IDLE. The load buffer may be rewritten meanwhile without affecting din_o.
- rst mid-frame or mid-WAIT: immediate return to reset state; the partial frame is lost, frame_cnt=0.

Decomposition:
- Shared package mac_pkg holds:
  - constants N=576, BEAT_BYTES=8, NUM_ACC=8;
  - derived BEATS=N/BEAT_BYTES;
  - enums for the loader states (LOAD, FULL, DRAIN) and issue states (IDLE, SETTLE, FIRE, WAIT).
- One sub-module, mac_frame_loader, contains the beat counter, load buffer and loader FSM, with full/ack handshake to the issue logic.
- The issue FSM, done mask and counters live in the top.

Test Plan:
- Single frame: stream 72 beats where byte value = index mod 256, s_last on beat 71; tie sum_vld_i=8'hFF 3 cycles after FIRE. Required: din_o byte 575 = 8'h3F; vld_o=8'hFF for one cycle 2 cycles after din_o update (MUL_LAT=1); frame_cnt=1; busy=0 afterwards.
- Back-to-back: stream frames A and B continuously; delay sum_vld_i for A by 100 cycles. Required: s_ready=0 after B's beat 71 until A completes; B appears on din_o 2 cycles after A's completion cycle; frame_cnt=2.
- Staggered lanes: in WAIT, pulse sum_vld_i lanes 0..7 one per cycle, repeating lane 3 twice. Required: busy stays 1 until the lane-7 cycle; completion happens once; frame_cnt increments by exactly 1.
- Early s_last on beat 10: frame_err pulses once; nothing issued; a following 72-beat frame issues normally with correct byte mapping.
- Missing s_last: beats 0..71 without s_last, then 3 extra beats with s_last on the third. Required: frame_err pulse; frame issued; the 3 extra beats are discarded; the next frame loads from beat 0.
- Reset in WAIT: assert rst for 1 cycle. Required: all outputs 0 asynchronously; s_ready=1 the cycle after release; a subsequent frame completes with frame_cnt=1.
